// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions used by both the read and write channels
// of the coprocessor's register slave.
package axilite_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

endpackage

// File: rtl/axilite_strb_merge.sv
// Byte-lane merge: each strobe bit selects the new byte, otherwise the
// old byte of the register word is kept.
module axilite_strb_merge
  import axilite_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/axilite_write_channel.sv
// AXI4-Lite write path (AW/W/B) owning the coprocessor's control register
// bank, with a one-cycle per-register commit strobe.
module axilite_write_channel
  import axilite_pkg::*;
#(
  parameter int                NREGS     = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [STRB_W-1:0]       wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [DATA_W*NREGS-1:0] regs,
  output logic [NREGS-1:0]        wr_pulse
);

  logic              aw_held;
  logic              w_held;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic              bvalid_q;
  resp_t             bresp_q;

  logic [DATA_W-1:0] bank   [NREGS];
  logic [DATA_W-1:0] merged [NREGS];

  logic commit;
  logic in_range;

  // Readies depend on held state only, so a stalled response blocks both channels.
  assign awready  = ~aw_held & ~bvalid_q;
  assign wready   = ~w_held & ~bvalid_q;
  assign commit   = aw_held & w_held;
  assign in_range = (addr_q < 32'(NREGS));
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
      if (awvalid && awready) begin
        addr_q  <= awaddr;
        aw_held <= 1'b1;
      end
      if (wvalid && wready) begin
        data_q <= wdata;
        strb_q <= wstrb;
        w_held <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_word
    axilite_strb_merge u_merge (
      .old_word (bank[i]),
      .new_word (data_q),
      .strb     (strb_q),
      .merged   (merged[i])
    );
    assign regs[DATA_W*i +: DATA_W] = bank[i];
  end

  // The pulse fires on every in-range commit, even an all-zero strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bank[i] <= RESET_VAL;
      end
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NREGS; i++) begin
        if (commit && in_range && (addr_q == 32'(i))) begin
          bank[i]     <= merged[i];
          wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axilite_write_channel.sv
// Randomized self-checking bench for axilite_write_channel, compared every
// cycle against a transaction-level model of the register slave.
module tb_axilite_write_channel;

  localparam int          NREGS     = 4;
  localparam logic [31:0] RESET_VAL = 32'hA5A5_5A5A;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        awaddr = '0;
  logic               awvalid = 1'b0;
  logic               awready;
  logic [31:0]        wdata = '0;
  logic [3:0]         wstrb = '0;
  logic               wvalid = 1'b0;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready = 1'b0;
  logic [32*NREGS-1:0] regs;
  logic [NREGS-1:0]   wr_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  axilite_write_channel #(.NREGS(NREGS), .RESET_VAL(RESET_VAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .regs     (regs),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  // Transaction-level model: a pending address, pending data and one response.
  logic [31:0]      m_regs [NREGS];
  bit               m_aw_pend, m_w_pend, m_bv;
  logic [31:0]      m_addr, m_data;
  logic [3:0]       m_strb;
  logic [1:0]       m_resp;
  logic [NREGS-1:0] m_pulse;

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = RESET_VAL;
    m_aw_pend = 0;
    m_w_pend  = 0;
    m_bv      = 0;
    m_resp    = 2'b00;
    m_pulse   = '0;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[32*i +: 32] = m_regs[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit acc_aw, acc_w;
    if (!rst) begin
      m_reset();
    end else begin
      m_pulse = '0;
      acc_aw  = awvalid && !m_aw_pend && !m_bv;
      acc_w   = wvalid && !m_w_pend && !m_bv;
      if (m_aw_pend && m_w_pend) begin
        if (m_addr < 32'(NREGS)) begin
          for (int k = 0; k < 4; k++)
            if (m_strb[k]) m_regs[m_addr][8*k +: 8] = m_data[8*k +: 8];
          m_pulse[m_addr] = 1'b1;
          m_resp = 2'b00;
        end else begin
          m_resp = 2'b10;
        end
        m_bv      = 1;
        m_aw_pend = 0;
        m_w_pend  = 0;
      end else begin
        if (m_bv && bready) m_bv = 0;
        if (acc_aw) begin m_addr = awaddr; m_aw_pend = 1; end
        if (acc_w)  begin m_data = wdata; m_strb = wstrb; m_w_pend = 1; end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("awready", awready, !m_aw_pend && !m_bv);
      chk("wready", wready, !m_w_pend && !m_bv);
      chk("bvalid", bvalid, m_bv);
      if (m_bv) chk("bresp", bresp, m_resp);
      chk("regs", regs, m_flat());
      chk("wr_pulse", wr_pulse, m_pulse);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one write with independent AW/W delays and B backpressure.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int b_wait, input bit early,
                          output logic [1:0] resp, output logic [NREGS-1:0] pulses,
                          output int bv_cyc);
    bit aw_done = 0, w_done = 0, done = 0;
    int bcnt = 0;
    pulses = '0;
    resp   = 2'bxx;
    bv_cyc = -1;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      pulses |= wr_pulse;
      if (bvalid && bv_cyc < 0) bv_cyc = cyc;
      awaddr  = addr;
      awvalid = !aw_done && (cyc >= aw_dly);
      wdata   = data;
      wstrb   = strb;
      wvalid  = !w_done && (cyc >= w_dly);
      bready  = bvalid ? (bcnt >= b_wait) : early;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done = 1;
      if (bvalid && bready) begin resp = bresp; done = 1; end
      if (bvalid) bcnt++;
      step();
    end
    awvalid = 0;
    wvalid  = 0;
    bready  = 0;
    chk("write completes", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]       resp;
    logic [NREGS-1:0] pulses;
    int               bv_cyc;
    logic [127:0]     snap;
    logic [31:0]      addr;
    int               r;

    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset regs", regs, {4{RESET_VAL}});
    chk("reset bvalid", bvalid, 1'b0);
    chk("reset wr_pulse", wr_pulse, 4'b0000);
    step();

    // AW and W together.
    do_write(32'd1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b1, resp, pulses, bv_cyc);
    chk("t1 bresp", resp, 2'b00);
    chk("t1 latency", bv_cyc, 2);
    chk("t1 pulse", pulses, 4'b0010);
    chk("t1 regs", regs, {RESET_VAL, RESET_VAL, 32'hDEAD_BEEF, RESET_VAL});
    chk("t1 model", m_regs[1], 32'hDEAD_BEEF);

    // W leads AW by three cycles.
    do_write(32'd0, 32'h1234_5678, 4'hF, 3, 0, 0, 1'b1, resp, pulses, bv_cyc);
    chk("t2 latency", bv_cyc, 5);
    chk("t2 word0", regs[31:0], 32'h1234_5678);

    // Partial strobe over a preloaded word.
    do_write(32'd2, 32'hAABB_CCDD, 4'hF, 1, 0, 2, 1'b0, resp, pulses, bv_cyc);
    do_write(32'd2, 32'h1122_3344, 4'b0101, 0, 2, 0, 1'b0, resp, pulses, bv_cyc);
    chk("t3 bresp", resp, 2'b00);
    chk("t3 word2", regs[95:64], 32'hAA22_CC44);
    chk("t3 model", m_regs[2], 32'hAA22_CC44);

    // Out-of-range address, no wrap to word 0.
    snap = regs;
    do_write(32'd4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1'b1, resp, pulses, bv_cyc);
    chk("t4 bresp", resp, 2'b10);
    chk("t4 regs", regs, snap);
    chk("t4 pulse", pulses, 4'b0000);

    // Backpressure: response stalls, a new AW waits behind it.
    awaddr = 32'd3; wdata = 32'h0F0F_0F0F; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    step();
    awvalid = 0; wvalid = 0;
    step();
    chk("t5 bvalid up", bvalid, 1'b1);
    awaddr = 32'd0; awvalid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t5 awready stall", awready, 1'b0);
      chk("t5 wready stall", wready, 1'b0);
      chk("t5 bvalid hold", bvalid, 1'b1);
      chk("t5 bresp hold", bresp, 2'b00);
      step();
    end
    bready = 1;
    chk("t5 awready at bready", awready, 1'b0);
    step();
    bready = 0;
    chk("t5 bvalid cleared", bvalid, 1'b0);
    chk("t5 awready after B", awready, 1'b1);
    step();
    awvalid = 0;
    chk("t5 aw taken", awready, 1'b0);
    wdata = 32'h0BAD_F00D; wvalid = 1;
    step();
    wvalid = 0;
    step();
    chk("t5 second bvalid", bvalid, 1'b1);
    bready = 1;
    step();
    bready = 0;
    chk("t5 word3", regs[127:96], 32'h0F0F_0F0F);
    chk("t5 word0", regs[31:0], 32'h0BAD_F00D);

    // Asynchronous reset after AW, before W.
    awaddr = 32'd2; awvalid = 1;
    step();
    awvalid = 0;
    #1 rst = 1'b0;
    #1;
    chk("t6 async bvalid", bvalid, 1'b0);
    chk("t6 async regs", regs, {4{RESET_VAL}});
    chk("t6 async awready", awready, 1'b1);
    @(negedge clk);
    #1 rst = 1'b1;
    step();
    do_write(32'd2, 32'hCAFE_F00D, 4'hF, 0, 1, 1, 1'b0, resp, pulses, bv_cyc);
    chk("t6 fresh bresp", resp, 2'b00);
    chk("t6 fresh regs", regs, {RESET_VAL, 32'hCAFE_F00D, RESET_VAL, RESET_VAL});
    chk("t6 fresh pulse", pulses, 4'b0100);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 32'(r);
      else if (r < 8) addr = 32'h8000_0000 | 32'(r);
      else            addr = 32'h0000_0100 + 32'(r);
      do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               resp, pulses, bv_cyc);
      chk("rand bresp", resp, (addr < 32'(NREGS)) ? 2'b00 : 2'b10);
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
